puzzle_game_sequencer: RTL and testbench

- Front end for the 2x2 sliding-puzzle move controller.
- Conditions the raw push-buttons and issues single-cycle move pulses on act[3:0].
- Drives the game_status phase sequence and presents the selected start board.
- Watches the controller's win_flag and counts moves for the display.

---
 rtl/puzzle_pkg.sv | 55 +++++
 rtl/puzzle_game_sequencer_btn_debounce.sv | 50 +++++
 rtl/puzzle_game_sequencer.sv | 149 ++++++++++++++
 tb/tb_puzzle_game_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// ----------------------------------------------------------------------------
// puzzle_pkg
// Shared definitions for the 2x2 sliding-puzzle front end:
//   - game_status encodings seen by the move controller
//   - button bit positions (direction buttons, then confirm, then restart)
//   - the four selectable start boards (4 tiles x 3 bits)
//   - helpers: start-board lookup, lowest-index direction pick
// None of the start boards is a solved pattern once slot [5:3] is blanked,
// so a freshly loaded game can never win before a move is made.
// ----------------------------------------------------------------------------
package puzzle_pkg;

  localparam logic [1:0] CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GAMING       = 2'b01;
  localparam logic [1:0] GAME_INITIAL = 2'b10;
  localparam logic [1:0] WINNED       = 2'b11;

  localparam int DIR_UP      = 0;
  localparam int DIR_RIGHT   = 1;
  localparam int DIR_DOWN    = 2;
  localparam int DIR_LEFT    = 3;
  localparam int BTN_CONFIRM = 4;
  localparam int BTN_RESTART = 5;
  localparam int NUM_BTN     = 6;

  typedef logic [11:0] board_t;

  localparam board_t BOARD_0 = 12'b010_000_001_011;
  localparam board_t BOARD_1 = 12'b001_011_000_010;
  localparam board_t BOARD_2 = 12'b011_010_001_000;
  localparam board_t BOARD_3 = 12'b000_010_011_001;

  function automatic board_t board_lut(input logic [1:0] sel);
    board_t b;
    case (sel)
      2'd0:    b = BOARD_0;
      2'd1:    b = BOARD_1;
      2'd2:    b = BOARD_2;
      default: b = BOARD_3;
    endcase
    return b;
  endfunction

  // Simultaneous direction presses: lowest index wins, the rest are dropped.
  function automatic logic [3:0] lowest_dir(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if      (v[DIR_UP])    r[DIR_UP]    = 1'b1;
    else if (v[DIR_RIGHT]) r[DIR_RIGHT] = 1'b1;
    else if (v[DIR_DOWN])  r[DIR_DOWN]  = 1'b1;
    else if (v[DIR_LEFT])  r[DIR_LEFT]  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/puzzle_game_sequencer_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the rising edge of the debounced level.
// Ports:
//   clk_d   - game clock
//   reset   - async active-high reset, clears everything
//   i_btn   - raw button level
//   o_press - one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level flips on the edge where the counter already holds
// DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive disagreeing
// synced samples; the press pulse is registered on that same edge.
// ----------------------------------------------------------------------------
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk_d,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_flip = w_diff && (r_cnt == LIMIT);

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      o_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      o_press <= w_flip & r_sync[1];
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (w_flip) r_level <= r_sync[1];
    end
  end

endmodule

// File: rtl/puzzle_game_sequencer.sv
// ----------------------------------------------------------------------------
// puzzle_game_sequencer
// Front end for the 2x2 sliding-puzzle move controller: conditions the
// buttons, sequences game_status, presents the start board, issues one-cycle
// move pulses and counts moves.
// Ports:
//   clk_d, reset          - game clock, async active-high reset
//   btn_dir[3:0]          - raw up/right/down/left buttons
//   btn_confirm           - raw confirm button
//   btn_restart           - raw restart button
//   board_sel[1:0]        - start-board select, sampled while selecting
//   win_flag              - solved indication from the controller (lags 1 cycle)
//   game_status[1:0]      - 00 choose, 01 gaming, 10 initial/blank, 11 won
//   act[3:0]              - one-hot move pulse
//   origin_board[11:0]    - start board handed to the controller
//   game_rst              - board-load strobe (only in the LOAD cycle)
//   move_count[MOVE_W-1:0]- saturating count of issued moves since load
// ----------------------------------------------------------------------------
module puzzle_game_sequencer
  import puzzle_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16,
  parameter int          MOVE_W          = 8
) (
  input  logic              clk_d,
  input  logic              reset,
  input  logic [3:0]        btn_dir,
  input  logic              btn_confirm,
  input  logic              btn_restart,
  input  logic [1:0]        board_sel,
  input  logic              win_flag,
  output logic [1:0]        game_status,
  output logic [3:0]        act,
  output logic [11:0]       origin_board,
  output logic              game_rst,
  output logic [MOVE_W-1:0] move_count
);

  localparam logic [2:0] S_SELECT = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_BLANK  = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;
  localparam logic [2:0] S_WON    = 3'd5;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_press;
  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [1:0]         r_settle;
  logic [3:0]         r_act_d;
  logic [3:0]         r_held;
  logic [3:0]         w_held_next;
  logic [3:0]         w_issue;
  logic [3:0]         w_dir;
  logic               w_win_ok;

  function automatic logic [1:0] status_of(input logic [2:0] s);
    logic [1:0] st;
    case (s)
      S_LOAD:  st = GAMING;
      S_BLANK: st = GAME_INITIAL;
      S_PLAY:  st = GAMING;
      S_WON:   st = WINNED;
      default: st = CHOSE_BOARD;
    endcase
    return st;
  endfunction

  assign w_raw = {btn_restart, btn_confirm, btn_dir};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_d  (clk_d),
      .reset  (reset),
      .i_btn  (w_raw[gi]),
      .o_press(w_press[gi])
    );
  end

  assign w_dir = w_press[3:0];

  // win_flag reflects a move two cycles after its act pulse, so it is only
  // trusted once the settle window is over and no pulse is in that pipeline.
  assign w_win_ok = win_flag && (r_settle == 2'd0) && (act == 4'b0000) &&
                    (r_act_d == 4'b0000);

  always_comb begin
    w_next      = r_state;
    w_issue     = 4'b0000;
    w_held_next = 4'b0000;
    case (r_state)
      S_SELECT: if (w_press[BTN_CONFIRM]) w_next = S_LATCH;
      S_LATCH:  w_next = S_LOAD;
      S_LOAD:   w_next = S_BLANK;
      S_BLANK:  w_next = S_PLAY;
      S_PLAY: begin
        if (w_press[BTN_RESTART])  w_next = S_LATCH;
        else if (w_win_ok)         w_next = S_WON;
        else if (r_held != 4'b0)   w_issue = r_held;  // fresh press this cycle dropped
        else if (w_dir != 4'b0) begin
          // A press landing while a pulse is out waits one cycle to keep
          // pulses at least two cycles apart.
          if (act != 4'b0) w_held_next = lowest_dir(w_dir);
          else             w_issue     = lowest_dir(w_dir);
        end
      end
      S_WON: begin
        if (w_press[BTN_RESTART])      w_next = S_LATCH;
        else if (w_press[BTN_CONFIRM]) w_next = S_SELECT;
      end
      default: w_next = S_SELECT;
    endcase
  end

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_state      <= S_SELECT;
      game_status  <= CHOSE_BOARD;
      act          <= 4'b0000;
      r_act_d      <= 4'b0000;
      r_held       <= 4'b0000;
      game_rst     <= 1'b0;
      origin_board <= BOARD_0;
      move_count   <= '0;
      r_settle     <= 2'd0;
    end else begin
      r_state     <= w_next;
      game_status <= status_of(w_next);
      act         <= w_issue;
      r_act_d     <= act;
      r_held      <= w_held_next;
      game_rst    <= (w_next == S_LOAD);
      // Board only tracks board_sel while selecting; restart replays it.
      if (r_state == S_SELECT) origin_board <= board_lut(board_sel);
      if (w_next == S_LOAD)
        move_count <= '0;
      else if ((w_issue != 4'b0) && (move_count != {MOVE_W{1'b1}}))
        move_count <= move_count + MOVE_W'(1);
      if (r_state == S_BLANK)      r_settle <= 2'd2;
      else if (r_settle != 2'd0)   r_settle <= r_settle - 2'd1;
    end
  end

endmodule

// File: tb/tb_puzzle_game_sequencer.sv
// ----------------------------------------------------------------------------
// Bench for puzzle_game_sequencer with a 4-cycle debounce. A cycle-level
// model built from the rules (stable-sample windows, cycle distances between
// pulses and play entry) predicts every output; directed checks pin key
// cycles with hand-computed values.
// ----------------------------------------------------------------------------
module tb_puzzle_game_sequencer;

  localparam int DB = 4;

  logic        clk_d = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_dir = 4'b0;
  logic        btn_confirm = 1'b0;
  logic        btn_restart = 1'b0;
  logic [1:0]  board_sel = 2'd2;
  logic        win_flag = 1'b0;
  logic [1:0]  game_status;
  logic [3:0]  act;
  logic [11:0] origin_board;
  logic        game_rst;
  logic [7:0]  move_count;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk_d = ~clk_d;

  puzzle_game_sequencer #(
    .DEBOUNCE_CYCLES(16'd4),
    .CNT_W          (16),
    .MOVE_W         (8)
  ) dut (
    .clk_d       (clk_d),
    .reset       (reset),
    .btn_dir     (btn_dir),
    .btn_confirm (btn_confirm),
    .btn_restart (btn_restart),
    .board_sel   (board_sel),
    .win_flag    (win_flag),
    .game_status (game_status),
    .act         (act),
    .origin_board(origin_board),
    .game_rst    (game_rst),
    .move_count  (move_count)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_d);
  endtask

  // ---------------- model ----------------
  localparam int P_SEL = 0, P_LATCH = 1, P_LOAD = 2, P_BLANK = 3, P_PLAY = 4, P_WON = 5;

  function automatic logic [11:0] tb_board(input logic [1:0] s);
    case (s)
      2'd0:    return 12'b010000001011;
      2'd1:    return 12'b001011000010;
      2'd2:    return 12'b011010001000;
      default: return 12'b000010011001;
    endcase
  endfunction

  int          m_ph, m_e, m_entry, m_last, m_nxt;
  logic [3:0]  m_held, m_held_nx, m_iss, m_cand;
  logic [5:0]  m_press, m_db, m_raw;
  logic [15:0] m_hist [6];
  logic        m_stable;
  logic [1:0]  e_status;
  logic [3:0]  e_act;
  logic [11:0] e_board;
  logic        e_grst;
  int          e_cnt;

  always @(posedge clk_d or posedge reset) begin
    if (reset) begin
      m_ph = P_SEL; m_e = 0; m_entry = -100; m_last = -100;
      m_held = 0; m_press = 0; m_db = 0;
      for (int i = 0; i < 6; i++) m_hist[i] = 0;
      e_status = 0; e_act = 0; e_board = tb_board(2'd0); e_grst = 0; e_cnt = 0;
    end else begin
      m_e++;
      m_iss = 0; m_held_nx = 0; m_nxt = m_ph;
      if (m_ph == P_SEL) e_board = tb_board(board_sel);
      case (m_ph)
        P_SEL:   if (m_press[4]) m_nxt = P_LATCH;
        P_LATCH: m_nxt = P_LOAD;
        P_LOAD:  m_nxt = P_BLANK;
        P_BLANK: begin m_nxt = P_PLAY; m_entry = m_e; end
        P_PLAY: begin
          if (m_press[5]) m_nxt = P_LATCH;
          else if (win_flag && (m_e - m_entry >= 3) && (m_e - m_last >= 3)) m_nxt = P_WON;
          else if (m_held != 0) m_iss = m_held;
          else if (m_press[3:0] != 0) begin
            m_cand = 0;
            for (int b = 3; b >= 0; b--) if (m_press[b]) m_cand = 4'(1 << b);
            if (m_e - m_last >= 2) m_iss = m_cand;
            else m_held_nx = m_cand;
          end
        end
        default: begin
          if (m_press[5]) m_nxt = P_LATCH;
          else if (m_press[4]) m_nxt = P_SEL;
        end
      endcase
      m_held = m_held_nx;
      if (m_iss != 0) begin
        m_last = m_e;
        if (e_cnt < 255) e_cnt++;
      end
      if (m_nxt == P_LOAD) e_cnt = 0;
      m_ph = m_nxt;
      e_act = m_iss;
      e_grst = (m_ph == P_LOAD);
      case (m_ph)
        P_LOAD, P_PLAY: e_status = 2'b01;
        P_BLANK:        e_status = 2'b10;
        P_WON:          e_status = 2'b11;
        default:        e_status = 2'b00;
      endcase
      // Debounced level changes after DB consecutive synced samples that
      // disagree with it; synced sample = raw two edges earlier.
      m_raw = {btn_restart, btn_confirm, btn_dir};
      for (int i = 0; i < 6; i++) begin
        m_hist[i] = {m_hist[i][14:0], m_raw[i]};
        m_press[i] = 1'b0;
        m_stable = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (m_hist[i][j] == m_db[i]) m_stable = 1'b0;
        if (m_stable) begin
          m_db[i] = ~m_db[i];
          m_press[i] = m_db[i];
        end
      end
    end
  end

  always @(negedge clk_d) begin
    if (!reset)
      chk("outputs{status,act,board,grst,cnt}",
          {5'd0, game_status, act, origin_board, game_rst, move_count},
          {5'd0, e_status, e_act, e_board, e_grst, e_cnt[7:0]});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    wait_n(2);
    chk("rst_status", 32'(game_status), 0);
    chk("rst_act", 32'(act), 0);
    chk("rst_grst", 32'(game_rst), 0);
    chk("rst_cnt", 32'(move_count), 0);
    chk("rst_board", 32'(origin_board), 32'b010000001011);
    reset = 1'b0;
    wait_n(3);
    chk("sel_board2", 32'(origin_board), 32'b011010001000);

    // 1. confirm -> 00,00,01(grst),10,01
    btn_confirm = 1; wait_n(6); btn_confirm = 0;
    wait_n(1); chk("t1_latch_status", 32'(game_status), 0);
    wait_n(1); chk("t1_load_status", 32'(game_status), 1); chk("t1_load_grst", 32'(game_rst), 1);
    chk("t1_load_cnt", 32'(move_count), 0);
    wait_n(1); chk("t1_blank_status", 32'(game_status), 2);
    wait_n(1); chk("t1_play_status", 32'(game_status), 1); chk("t1_play_grst", 32'(game_rst), 0);
    wait_n(10);

    // 2. glitch then stable right press
    btn_dir = 4'b0010; wait_n(2); btn_dir = 0;
    wait_n(5); chk("t2_glitch_act", 32'(act), 0);
    wait_n(10);
    btn_dir = 4'b0010; wait_n(6); chk("t2_pre_act", 32'(act), 0); btn_dir = 0;
    wait_n(1); chk("t2_act", 32'(act), 32'b0010);
    wait_n(1); chk("t2_act_end", 32'(act), 0); chk("t2_cnt", 32'(move_count), 1);
    wait_n(10);

    // 3. up+left together, then right landing on an act pulse
    btn_dir = 4'b1001; wait_n(6); btn_dir = 0;
    wait_n(1); chk("t3_lowest", 32'(act), 32'b0001); chk("t3_cnt", 32'(move_count), 2);
    wait_n(10);
    btn_dir = 4'b0001; wait_n(1); btn_dir = 4'b0011; wait_n(5); btn_dir = 4'b0010;
    wait_n(1); chk("t3_up", 32'(act), 32'b0001); btn_dir = 0;
    wait_n(1); chk("t3_gap", 32'(act), 0);
    wait_n(1); chk("t3_held_right", 32'(act), 32'b0010); chk("t3_cnt4", 32'(move_count), 4);
    wait_n(10);

    // 5. restart with board_sel changed: replays BOARD_2
    board_sel = 2'd0;
    btn_restart = 1; wait_n(6); btn_restart = 0;
    wait_n(1); chk("t5_latch_status", 32'(game_status), 0);
    chk("t5_board_kept", 32'(origin_board), 32'b011010001000);
    wait_n(1); chk("t5_load_grst", 32'(game_rst), 1); chk("t5_cnt0", 32'(move_count), 0);
    wait_n(1); chk("t5_blank", 32'(game_status), 2);
    wait_n(1); chk("t5_play", 32'(game_status), 1);

    // 4. win during settle and right after a pulse is ignored
    win_flag = 1; wait_n(2); win_flag = 0;
    wait_n(1); chk("t4_settle_nowin", 32'(game_status), 1);
    wait_n(8);
    btn_dir = 4'b0001; wait_n(6); btn_dir = 0;
    wait_n(1); chk("t4_act", 32'(act), 32'b0001);
    win_flag = 1; wait_n(2); win_flag = 0;
    wait_n(1); chk("t4_postact_nowin", 32'(game_status), 1);
    wait_n(8);
    win_flag = 1; wait_n(1); chk("t4_won", 32'(game_status), 3);
    btn_dir = 4'b0100; wait_n(6); btn_dir = 0;
    wait_n(1); chk("t4_won_noact", 32'(act), 0); chk("t4_won_stay", 32'(game_status), 3);
    wait_n(6);
    board_sel = 2'd3;
    btn_confirm = 1; wait_n(6); btn_confirm = 0;
    wait_n(1); chk("t4_to_select", 32'(game_status), 0); win_flag = 0;
    wait_n(10);

    // 6. saturation and async reset
    btn_confirm = 1; wait_n(6); btn_confirm = 0;
    wait_n(4); chk("t6_play", 32'(game_status), 1);
    chk("t6_board3", 32'(origin_board), 32'b000010011001);
    for (int i = 0; i < 256; i++) begin
      btn_dir = 4'b0100; wait_n(6); btn_dir = 0; wait_n(6);
      if (i == 254) chk("t6_cnt255", 32'(move_count), 255);
    end
    chk("t6_cnt_hold", 32'(move_count), 255);
    @(negedge clk_d); #2 reset = 1'b1; #1;
    chk("t6_rst_status", 32'(game_status), 0);
    chk("t6_rst_act", 32'(act), 0);
    chk("t6_rst_cnt", 32'(move_count), 0);
    chk("t6_rst_board", 32'(origin_board), 32'b010000001011);
    wait_n(2); reset = 1'b0;
    wait_n(3); chk("t6_after_rst", 32'(game_status), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
